// File: rtl/depacketizer_pkg.sv
// depacketizer_pkg: shared types and width helpers for the depacketizer arbiter
package depacketizer_pkg;
    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int head_valid_bit(input int width_pkt);
        return width_pkt - 1;
    endfunction
endpackage

// File: rtl/depacketizer_arbiter_if.sv
// depacketizer_arbiter_if: requester-side and depacketizer-side handshake bundle
interface depacketizer_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH_PKT = 36
);
    import depacketizer_pkg::*;
    localparam int W_ID = clog2_min1(NUM_REQ);
    logic [NUM_REQ*WIDTH_PKT-1:0] req_data_in;
    logic [NUM_REQ-1:0]           req_valid_in;
    logic [NUM_REQ-1:0]           req_ready_out;
    logic [WIDTH_PKT-1:0]         data_out;
    logic                         valid_out;
    logic                         ready_in;
    logic [W_ID-1:0]              grant_id_out;
    modport master (
        output req_data_in, req_valid_in, ready_in,
        input  req_ready_out, data_out, valid_out, grant_id_out
    );
    modport slave (
        input  req_data_in, req_valid_in, ready_in,
        output req_ready_out, data_out, valid_out, grant_id_out
    );
endinterface

// File: rtl/depacketizer_arbiter_rr_picker.sv
// rr_picker: rotating-priority encoder, first set request after index last
module rr_picker
    import depacketizer_pkg::*;
#(
    parameter int N = 4,
    localparam int W = clog2_min1(N)
)(
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_last,
    output logic         o_found,
    output logic [W-1:0] o_idx
);
    logic [W-1:0] w_c;

    // Scan from farthest to nearest so the nearest candidate is written last
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_c     = '0;
        for (int k = N; k >= 1; k--) begin
            w_c = W'((int'(i_last) + k) % N);
            if (i_req[w_c]) begin
                o_found = 1'b1;
                o_idx   = w_c;
            end
        end
    end
endmodule

// File: rtl/depacketizer_arbiter.sv
// depacketizer_arbiter: round-robin packet arbiter with burst lock, empty-packet filter
// and a single registered output stage feeding the depacketizer
module depacketizer_arbiter
    import depacketizer_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH_PKT = 36,
    parameter int MAX_BURST = 4
)(
    input  logic                  clk,
    input  logic                  rst_n,
    depacketizer_arbiter_if.slave bus
);
    localparam int W_ID           = clog2_min1(NUM_REQ);
    localparam int W_CNT          = clog2_min1(MAX_BURST + 1);
    localparam int HEAD_VALID_BIT = head_valid_bit(WIDTH_PKT);

    arb_state_t           r_state;
    logic [W_CNT-1:0]     r_burst_cnt;
    logic [W_ID-1:0]      r_last, r_owner, r_grant_id;
    logic [WIDTH_PKT-1:0] r_data;
    logic                 r_valid;
    logic [W_ID-1:0]      w_rr_idx, w_grant;
    logic [WIDTH_PKT-1:0] w_pkt;
    logic                 w_rr_found, w_can_load, w_grant_valid, w_xfer, w_load, w_burst_end;

    rr_picker #(.N(NUM_REQ)) u_picker (
        .i_req  (bus.req_valid_in),
        .i_last (r_last),
        .o_found(w_rr_found),
        .o_idx  (w_rr_idx)
    );

    assign w_can_load    = ~r_valid | bus.ready_in;
    assign w_grant       = (r_state == ARB_BURST) ? r_owner : w_rr_idx;
    assign w_grant_valid = (r_state == ARB_BURST) ? bus.req_valid_in[r_owner] : w_rr_found;
    assign w_xfer        = w_grant_valid & w_can_load;
    assign w_pkt         = bus.req_data_in[w_grant*WIDTH_PKT +: WIDTH_PKT];
    assign w_load        = w_xfer & w_pkt[HEAD_VALID_BIT];
    assign w_burst_end   = int'(r_burst_cnt) + 1 >= MAX_BURST;

    assign bus.req_ready_out = {{(NUM_REQ-1){1'b0}}, w_xfer} << w_grant;
    assign bus.data_out      = r_data;
    assign bus.valid_out     = r_valid;
    assign bus.grant_id_out  = r_grant_id;

    // Empty packets are consumed upstream but never occupy the output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_grant_id <= '0;
        end else if (w_load) begin
            r_valid    <= 1'b1;
            r_data     <= w_pkt;
            r_grant_id <= w_grant;
        end else if (bus.ready_in) begin
            r_valid    <= 1'b0;
        end
    end

    // Burst ends on exhaustion or when the owner goes quiet while the output could accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_burst_cnt <= '0;
            r_last      <= W_ID'(NUM_REQ - 1);
            r_owner     <= '0;
        end else if (r_state == ARB_IDLE) begin
            if (w_load && MAX_BURST > 1) begin
                r_state     <= ARB_BURST;
                r_owner     <= w_grant;
                r_burst_cnt <= W_CNT'(1);
            end else if (w_xfer) begin
                r_last      <= w_grant;
            end
        end else if (w_load ? w_burst_end : (~bus.req_valid_in[r_owner] & w_can_load)) begin
            r_state     <= ARB_IDLE;
            r_last      <= r_owner;
            r_burst_cnt <= '0;
        end else if (w_load) begin
            r_burst_cnt <= r_burst_cnt + W_CNT'(1);
        end
    end
endmodule

// File: tb/tb_depacketizer_arbiter.sv
// tb_depacketizer_arbiter: cycle table of handshake expectations plus a packet scoreboard
module tb_depacketizer_arbiter;
    localparam int N  = 4;
    localparam int WP = 36;
    localparam int MB = 4;

    typedef struct {
        bit         rst;
        logic [3:0] v;
        logic [3:0] e;
        logic       rdy;
        logic [3:0] er;
        logic       ev;
        logic [1:0] eg;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    int            checks = 0;
    int            failures = 0;
    logic [WP-1:0] sb[$];
    vec_t          tbl[$];
    vec_t          tv;
    logic [15:0]   seq[N];
    logic [N-1:0]  emask;

    depacketizer_arbiter_if #(.NUM_REQ(N), .WIDTH_PKT(WP)) bus();

    depacketizer_arbiter #(.NUM_REQ(N), .WIDTH_PKT(WP), .MAX_BURST(MB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Packet: head-valid, 0, source id, 16'h0, per-source sequence number
    task automatic drive_data();
        for (int s = 0; s < N; s++)
            bus.req_data_in[s*WP +: WP] = {~emask[s], 1'b0, 2'(s), 16'h0, seq[s]};
    endtask

    task automatic add(input bit r, input logic [3:0] v, input logic [3:0] e, input logic rdy,
                       input logic [3:0] er, input logic ev, input logic [1:0] eg);
        vec_t t;
        t = '{r, v, e, rdy, er, ev, eg};
        tbl.push_back(t);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid_in = '1;
        bus.ready_in = 1'b1;
        emask = '0;
        for (int s = 0; s < N; s++) seq[s] = '0;
        drive_data();
        sb.delete();
        @(negedge clk);
        check("rst_valid", 64'(bus.valid_out), 64'd0);
        check("rst_data", 64'(bus.data_out), 64'd0);
        check("rst_gid", 64'(bus.grant_id_out), 64'd0);
        rst_n = 1'b1;
        bus.req_valid_in = '0;
    endtask

    task automatic step(input vec_t t);
        logic [N-1:0]  adv;
        logic [WP-1:0] exp;
        @(negedge clk);
        bus.req_valid_in = t.v;
        bus.ready_in = t.rdy;
        emask = t.e;
        drive_data();
        #1;
        check("req_ready", 64'(bus.req_ready_out), 64'(t.er));
        if (bus.valid_out && bus.ready_in) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL ghost_packet act=%0h exp=none", bus.data_out);
            end else begin
                exp = sb.pop_front();
                check("sb_data", 64'(bus.data_out), 64'(exp));
                check("sb_gid", 64'(bus.grant_id_out), 64'(exp[33:32]));
            end
        end
        adv = bus.req_valid_in & bus.req_ready_out;
        for (int s = 0; s < N; s++)
            if (adv[s] && bus.req_data_in[s*WP+WP-1]) sb.push_back(bus.req_data_in[s*WP +: WP]);
        @(posedge clk);
        #1;
        for (int s = 0; s < N; s++)
            if (adv[s]) seq[s] = seq[s] + 16'd1;
        drive_data();
        check("valid_out", 64'(bus.valid_out), 64'(t.ev));
        if (t.ev) check("grant_id", 64'(bus.grant_id_out), 64'(t.eg));
    endtask

    initial begin
        bus.req_valid_in = '0;
        bus.ready_in = 1'b1;
        emask = '0;
        for (int s = 0; s < N; s++) seq[s] = '0;
        drive_data();
        // All requesters saturating: four-packet bursts rotating 0..3 then back to 0
        for (int k = 0; k < 17; k++)
            add(k == 0, 4'hF, 4'h0, 1'b1, 4'(1 << ((k / 4) % 4)), 1'b1, 2'((k / 4) % 4));
        // Owner 2 drops after two packets; search then resumes after 2
        add(1, 4'b1100, 4'h0, 1'b1, 4'b0100, 1'b1, 2'd2);
        add(0, 4'b1100, 4'h0, 1'b1, 4'b0100, 1'b1, 2'd2);
        add(0, 4'b1000, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0);
        for (int k = 0; k < 4; k++) add(0, 4'b1100, 4'h0, 1'b1, 4'b1000, 1'b1, 2'd3);
        add(0, 4'b1100, 4'h0, 1'b1, 4'b0100, 1'b1, 2'd2);
        // Req 1 only sends empty packets; owner-empty packets do not advance the burst
        for (int k = 0; k < 4; k++) add(k == 0, 4'b0011, 4'b0010, 1'b1, 4'b0001, 1'b1, 2'd0);
        add(0, 4'b0011, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0);
        for (int k = 0; k < 4; k++) add(0, 4'b0011, 4'b0010, 1'b1, 4'b0001, 1'b1, 2'd0);
        add(0, 4'b0011, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0);
        add(0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0);
        add(0, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0);
        add(0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0);
        add(0, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0);
        add(0, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0);
        add(0, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0);
        add(0, 4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1);
        // Five-cycle stall in the middle of a burst
        add(1, 4'hF, 4'h0, 1'b1, 4'b0001, 1'b1, 2'd0);
        add(0, 4'hF, 4'h0, 1'b1, 4'b0001, 1'b1, 2'd0);
        for (int k = 0; k < 5; k++) add(0, 4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 2'd0);
        add(0, 4'hF, 4'h0, 1'b1, 4'b0001, 1'b1, 2'd0);
        add(0, 4'hF, 4'h0, 1'b1, 4'b0001, 1'b1, 2'd0);
        add(0, 4'hF, 4'h0, 1'b1, 4'b0010, 1'b1, 2'd1);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i]);
        end

        // Async reset while a stalled packet sits in the output register
        do_reset();
        tv = '{0, 4'b0001, 4'h0, 1'b1, 4'b0001, 1'b1, 2'd0};
        step(tv);
        tv = '{0, 4'b0001, 4'h0, 1'b0, 4'b0000, 1'b1, 2'd0};
        step(tv);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 64'(bus.valid_out), 64'd0);
        check("async_data", 64'(bus.data_out), 64'd0);
        check("async_gid", 64'(bus.grant_id_out), 64'd0);
        sb.delete();
        bus.req_valid_in = '1;
        @(negedge clk);
        rst_n = 1'b1;
        bus.ready_in = 1'b1;
        bus.req_valid_in = '0;
        for (int s = 0; s < N; s++) seq[s] = '0;
        drive_data();
        tv = '{0, 4'hF, 4'h0, 1'b1, 4'b0001, 1'b1, 2'd0};
        step(tv);
        step(tv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
